// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped machine timer peripheral.
//
// Provides a 64-bit free-running mtime with a programmable prescaler, NUM_CMP
// independent 64-bit compare channels and level interrupt outputs. It sits on
// the core data bus beside block RAM. Reads are registered (1-cycle latency),
// and read_hit tells the core to select read_value over block RAM.
//
// Register map (word offsets from BASE_ADDRESS, C = 0x8 + 8*NUM_CMP):
//   +0x0       MTIME       mtime[31:0]
//   +0x4       MTIMEH      mtime[63:32] (shadow copy when snapshot is enabled)
//   +0x8+8i    MTIMECMP_i  mtimecmp_i[31:0]
//   +0xC+8i    MTIMECMPH_i mtimecmp_i[63:32]
//   C          CTRL        [0] enable, [8 +: PRESCALE_WIDTH] divisor,
//                          [16 +: NUM_CMP] irq enables
//   C+4        PENDING     read-only, bit i = (mtime >= mtimecmp_i)
//
// Ports:
//   clk24                 system clock
//   reset_n               asynchronous active-low reset
//   memory_address        core byte address (bits [1:0] ignored)
//   memory_write_value    lane-shifted write data
//   memory_write_sections lane strobes: [0]=7:0, [1]=15:8, [2]=31:16
//   memory_read_enable    core load this cycle (used only for the snapshot)
//   read_value            registered read data
//   read_hit              registered: address was inside the register window
//   timer_irq             per-channel level interrupt
//   timer_irq_any         OR of timer_irq
//
// Optional feature macro: MMIO_TIMER_SNAPSHOT_EN
//   Defined: a read of MTIME latches mtime[63:32] into a shadow, and MTIMEH
//   reads return that shadow, giving a tear-free low-then-high 64-bit read.
//   Undefined: MTIMEH returns live mtime[63:32].
//
// PRESCALE_WIDTH must be 1..8 so the divisor lives entirely in byte lane 1.

module mmio_timer #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int          NUM_CMP        = 2,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic               clk24,
  input  logic               reset_n,
  input  logic [31:0]        memory_address,
  input  logic [31:0]        memory_write_value,
  input  logic [2:0]         memory_write_sections,
  input  logic               memory_read_enable,
  output logic [31:0]        read_value,
  output logic               read_hit,
  output logic [NUM_CMP-1:0] timer_irq,
  output logic               timer_irq_any
);

  localparam logic [29:0] CTRL_WORD = 30'(2 + 2 * NUM_CMP);
  localparam logic [29:0] PEND_WORD = 30'(3 + 2 * NUM_CMP);
  localparam logic [29:0] NUM_WORDS = 30'(4 + 2 * NUM_CMP);

  logic [63:0]               r_mtime;
  logic [63:0]               r_cmp [NUM_CMP];
  logic                      r_enable;
  logic [PRESCALE_WIDTH-1:0] r_divisor;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [NUM_CMP-1:0]        r_irqEn;
  logic [31:0]               r_readValue;
  logic                      r_readHit;
  logic [NUM_CMP-1:0]        r_irq;
  logic                      r_irqAny;

  logic [29:0]               w_word;
  logic                      w_hit;
  logic                      w_write;
  logic                      w_mtimeLoWr;
  logic                      w_mtimeHiWr;
  logic                      w_ctrlWr;
  logic                      w_tick;
  logic [NUM_CMP-1:0]        w_pending;
  logic [31:0]               w_ctrlRead;
  logic [31:0]               w_mtimeHiRead;
  logic [31:0]               w_readMux;
  logic                      w_unused;

  // Replace only the byte lanes whose strobe is set; other lanes keep oldV.
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldV,
                                             input logic [31:0] newV,
                                             input logic [2:0]  sect);
    logic [31:0] merged;
    merged = oldV;
    if (sect[0]) merged[7:0]   = newV[7:0];
    if (sect[1]) merged[15:8]  = newV[15:8];
    if (sect[2]) merged[31:16] = newV[31:16];
    return merged;
  endfunction

  // Subtracting the base turns any address below the window into a huge
  // offset, so a single unsigned compare covers both window edges.
  assign w_word      = memory_address[31:2] - BASE_ADDRESS[31:2];
  assign w_hit       = (w_word < NUM_WORDS);
  assign w_write     = w_hit && (memory_write_sections != 3'b000);
  assign w_mtimeLoWr = w_write && (w_word == 30'd0);
  assign w_mtimeHiWr = w_write && (w_word == 30'd1);
  assign w_ctrlWr    = w_write && (w_word == CTRL_WORD);
  assign w_tick      = r_enable && (r_prescale == r_divisor);

  // Raw compare results, shared by PENDING and the interrupt registers.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      w_pending[i] = (r_mtime >= r_cmp[i]);
    end
  end

  // CTRL read image; unimplemented bits read as zero.
  always_comb begin
    w_ctrlRead = '0;
    w_ctrlRead[0] = r_enable;
    w_ctrlRead[8 +: PRESCALE_WIDTH] = r_divisor;
    w_ctrlRead[16 +: NUM_CMP] = r_irqEn;
  end

`ifdef MMIO_TIMER_SNAPSHOT_EN
  logic [31:0] r_shadow;

  // Capture the high word alongside every MTIME load so a following MTIMEH
  // load sees the value that belonged with the low word.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_hit && memory_read_enable && (w_word == 30'd0)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  assign w_mtimeHiRead = r_shadow;
  assign w_unused      = ^memory_address[1:0];
`else
  assign w_mtimeHiRead = r_mtime[63:32];
  assign w_unused      = ^{memory_read_enable, memory_address[1:0]};
`endif

  // Read multiplexer; anything outside the mapped registers reads zero.
  always_comb begin
    w_readMux = '0;
    if (w_word == 30'd0) w_readMux = r_mtime[31:0];
    if (w_word == 30'd1) w_readMux = w_mtimeHiRead;
    if (w_word == CTRL_WORD) w_readMux = w_ctrlRead;
    if (w_word == PEND_WORD) w_readMux = 32'(w_pending);
    for (int i = 0; i < NUM_CMP; i++) begin
      if (w_word == 30'(2 + 2 * i)) w_readMux = r_cmp[i][31:0];
      if (w_word == 30'(3 + 2 * i)) w_readMux = r_cmp[i][63:32];
    end
  end

  // mtime: a software write to either half wins over the prescaler tick, and
  // the untouched half keeps its pre-edge value rather than the incremented one.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_mtime <= '0;
    end else if (w_mtimeLoWr) begin
      r_mtime[31:0] <= mergeLanes(r_mtime[31:0], memory_write_value,
                                  memory_write_sections);
    end else if (w_mtimeHiWr) begin
      r_mtime[63:32] <= mergeLanes(r_mtime[63:32], memory_write_value,
                                   memory_write_sections);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // Prescaler: counts 0..divisor while enabled. Rewriting the divisor lane
  // restarts it so a new rate starts from a clean phase.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
    end else if (w_ctrlWr && memory_write_sections[1]) begin
      r_prescale <= '0;
    end else if (r_enable) begin
      r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
    end
  end

  // CTRL fields, each updated only when its byte lane is strobed.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_enable  <= 1'b1;
      r_divisor <= '0;
      r_irqEn   <= '1;
    end else if (w_ctrlWr) begin
      if (memory_write_sections[0]) r_enable  <= memory_write_value[0];
      if (memory_write_sections[1]) r_divisor <= memory_write_value[8 +: PRESCALE_WIDTH];
      if (memory_write_sections[2]) r_irqEn   <= memory_write_value[16 +: NUM_CMP];
    end
  end

  // Compare registers reset to all ones so no channel fires out of reset.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CMP; i++) r_cmp[i] <= '1;
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (w_write && (w_word == 30'(2 + 2 * i))) begin
          r_cmp[i][31:0] <= mergeLanes(r_cmp[i][31:0], memory_write_value,
                                       memory_write_sections);
        end
        if (w_write && (w_word == 30'(3 + 2 * i))) begin
          r_cmp[i][63:32] <= mergeLanes(r_cmp[i][63:32], memory_write_value,
                                        memory_write_sections);
        end
      end
    end
  end

  // Registered read path, sampled every cycle to match block RAM timing. It
  // sees pre-edge register state, so a same-cycle write is not visible yet.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_readValue <= '0;
      r_readHit   <= 1'b0;
    end else begin
      r_readValue <= w_hit ? w_readMux : 32'd0;
      r_readHit   <= w_hit;
    end
  end

  // Level interrupts, registered one cycle behind the compare state.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_irq    <= '0;
      r_irqAny <= 1'b0;
    end else begin
      r_irq    <= r_irqEn & w_pending;
      r_irqAny <= |(r_irqEn & w_pending);
    end
  end

  assign read_value    = r_readValue;
  assign read_hit      = r_readHit;
  assign timer_irq     = r_irq;
  assign timer_irq_any = r_irqAny;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer with the default
// parameters (BASE 0x8000_0000, NUM_CMP=2, PRESCALE_WIDTH=8). Inputs are
// driven and outputs sampled on the falling edge of clk24.

module tb_mmio_timer;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] A_MTIME  = BASE + 32'h00;
  localparam logic [31:0] A_MTIMEH = BASE + 32'h04;
  localparam logic [31:0] A_CMP0   = BASE + 32'h08;
  localparam logic [31:0] A_CMP0H  = BASE + 32'h0C;
  localparam logic [31:0] A_CMP1   = BASE + 32'h10;
  localparam logic [31:0] A_CMP1H  = BASE + 32'h14;
  localparam logic [31:0] A_CTRL   = BASE + 32'h18;
  localparam logic [31:0] A_PEND   = BASE + 32'h1C;

  logic        clk24;
  logic        reset_n;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [2:0]  memory_write_sections;
  logic        memory_read_enable;
  logic [31:0] read_value;
  logic        read_hit;
  logic [1:0]  timer_irq;
  logic        timer_irq_any;

  int          checkCount;
  int          passCount;
  logic [31:0] rdVal;
  logic        rdHit;
  logic [31:0] mtA;
  logic [31:0] mtB;
  logic [31:0] expHi;

  mmio_timer #(
    .BASE_ADDRESS   (BASE),
    .NUM_CMP        (2),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk24                 (clk24),
    .reset_n               (reset_n),
    .memory_address        (memory_address),
    .memory_write_value    (memory_write_value),
    .memory_write_sections (memory_write_sections),
    .memory_read_enable    (memory_read_enable),
    .read_value            (read_value),
    .read_hit              (read_hit),
    .timer_irq             (timer_irq),
    .timer_irq_any         (timer_irq_any)
  );

  initial begin
    clk24 = 1'b0;
    forever #5 clk24 = ~clk24;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus write, presented at a falling edge and committed at the next rise.
  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] sect);
    memory_address        = addr;
    memory_write_value    = data;
    memory_write_sections = sect;
    @(negedge clk24);
    memory_write_sections = 3'b000;
    memory_write_value    = 32'h0;
    memory_address        = 32'h0;
  endtask

  // One bus load; the value is the register state just before the next rise.
  task automatic applyRead(input logic [31:0] addr, output logic [31:0] val,
                           output logic hit);
    memory_address     = addr;
    memory_read_enable = 1'b1;
    @(negedge clk24);
    val                = read_value;
    hit                = read_hit;
    memory_read_enable = 1'b0;
    memory_address     = 32'h0;
  endtask

  task automatic test_reset;
    reset_n               = 1'b0;
    memory_address        = 32'h0;
    memory_write_value    = 32'h0;
    memory_write_sections = 3'b000;
    memory_read_enable    = 1'b0;
    repeat (3) @(negedge clk24);
    checkCount++;
    if (read_value !== 32'h0) $display("[TB] FAIL rst_read_value: got %h want %h", read_value, 32'h0);
    else passCount++;
    checkCount++;
    if (read_hit !== 1'b0) $display("[TB] FAIL rst_read_hit: got %b want 0", read_hit);
    else passCount++;
    checkCount++;
    if ({timer_irq_any, timer_irq} !== 3'b000) $display("[TB] FAIL rst_irq: got %b want 000", {timer_irq_any, timer_irq});
    else passCount++;
    reset_n = 1'b1;
    repeat (10) @(negedge clk24);
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'd10 || rdHit !== 1'b1) $display("[TB] FAIL idle_mtime: got %0d hit %b want 10 hit 1", rdVal, rdHit);
    else passCount++;
    checkCount++;
    if (timer_irq !== 2'b00) $display("[TB] FAIL idle_irq: got %b want 00", timer_irq);
    else passCount++;
    applyRead(A_PEND, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0 || rdHit !== 1'b1) $display("[TB] FAIL pend_window: got %h hit %b want 0 hit 1", rdVal, rdHit);
    else passCount++;
    applyRead(BASE - 32'd4, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0 || rdHit !== 1'b0) $display("[TB] FAIL below_base: got %h hit %b want 0 hit 0", rdVal, rdHit);
    else passCount++;
    applyRead(BASE + 32'h3, rdVal, rdHit);
    checkCount++;
    if (rdHit !== 1'b1) $display("[TB] FAIL byte_offset_hit: got %b want 1", rdHit);
    else passCount++;
  endtask

  task automatic test_prescaler;
    applyWrite(A_CTRL, 32'h0000_0301, 3'b011);
    applyRead(A_MTIME, mtA, rdHit);
    repeat (39) @(negedge clk24);
    applyRead(A_MTIME, mtB, rdHit);
    checkCount++;
    if (mtB - mtA !== 32'd10) $display("[TB] FAIL div3_rate: got %0d want 10", mtB - mtA);
    else passCount++;
    applyRead(BASE + 32'h20, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0 || rdHit !== 1'b0) $display("[TB] FAIL unmapped_read: got %h hit %b want 0 hit 0", rdVal, rdHit);
    else passCount++;
    applyWrite(A_CTRL, 32'h0000_0000, 3'b001);
    applyRead(A_MTIME, mtA, rdHit);
    repeat (5) @(negedge clk24);
    applyRead(A_MTIME, mtB, rdHit);
    checkCount++;
    if (mtB - mtA !== 32'd0) $display("[TB] FAIL disable_hold: got delta %0d want 0", mtB - mtA);
    else passCount++;
    applyRead(A_CTRL, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0003_0300) $display("[TB] FAIL ctrl_lanes: got %h want %h", rdVal, 32'h0003_0300);
    else passCount++;
    applyWrite(A_CTRL, 32'h0000_0001, 3'b011);
  endtask

  task automatic test_irq;
    applyWrite(A_CMP1, 32'd100, 3'b111);
    applyWrite(A_CMP1H, 32'd0, 3'b111);
    applyWrite(A_MTIME, 32'd90, 3'b111);
    applyWrite(A_MTIMEH, 32'd0, 3'b111);
    repeat (10) @(negedge clk24);
    checkCount++;
    if (timer_irq !== 2'b00) $display("[TB] FAIL irq_before_cmp: got %b want 00", timer_irq);
    else passCount++;
    @(negedge clk24);
    checkCount++;
    if (timer_irq !== 2'b10 || timer_irq_any !== 1'b1) $display("[TB] FAIL irq_rise: got %b any %b want 10 any 1", timer_irq, timer_irq_any);
    else passCount++;
    applyRead(A_PEND, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h2) $display("[TB] FAIL pending_ch1: got %h want %h", rdVal, 32'h2);
    else passCount++;
    applyWrite(A_CMP1H, 32'd1, 3'b111);
    checkCount++;
    if (timer_irq !== 2'b10) $display("[TB] FAIL irq_lag: got %b want 10", timer_irq);
    else passCount++;
    @(negedge clk24);
    checkCount++;
    if (timer_irq !== 2'b00 || timer_irq_any !== 1'b0) $display("[TB] FAIL irq_drop: got %b any %b want 00 any 0", timer_irq, timer_irq_any);
    else passCount++;
  endtask

  task automatic test_byte_write;
    applyWrite(A_MTIME, 32'h1234_56F0, 3'b111);
    repeat (15) @(negedge clk24);
    applyWrite(A_MTIME, 32'h0000_00AB, 3'b001);
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h1234_56AB) $display("[TB] FAIL byte_write: got %h want %h", rdVal, 32'h1234_56AB);
    else passCount++;
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h1234_56AC) $display("[TB] FAIL byte_resume: got %h want %h", rdVal, 32'h1234_56AC);
    else passCount++;
  endtask

  task automatic test_wrap;
    applyWrite(A_MTIMEH, 32'hFFFF_FFFF, 3'b111);
    applyWrite(A_MTIME, 32'hFFFF_FFFE, 3'b111);
    applyRead(A_PEND, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h2) $display("[TB] FAIL pend_max_cmp: got %h want %h", rdVal, 32'h2);
    else passCount++;
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'hFFFF_FFFF) $display("[TB] FAIL pre_wrap: got %h want %h", rdVal, 32'hFFFF_FFFF);
    else passCount++;
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0) $display("[TB] FAIL wrap_lo: got %h want %h", rdVal, 32'h0);
    else passCount++;
    applyRead(A_MTIMEH, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0) $display("[TB] FAIL wrap_hi: got %h want %h", rdVal, 32'h0);
    else passCount++;
    applyRead(A_PEND, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0) $display("[TB] FAIL pend_after_wrap: got %h want %h", rdVal, 32'h0);
    else passCount++;
  endtask

  task automatic test_snapshot;
`ifdef MMIO_TIMER_SNAPSHOT_EN
    expHi = 32'd0;
`else
    expHi = 32'd1;
`endif
    applyWrite(A_MTIMEH, 32'h0, 3'b111);
    applyWrite(A_MTIME, 32'hFFFF_FFFF, 3'b111);
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'hFFFF_FFFF) $display("[TB] FAIL snap_lo: got %h want %h", rdVal, 32'hFFFF_FFFF);
    else passCount++;
    repeat (2) @(negedge clk24);
    applyRead(A_MTIMEH, rdVal, rdHit);
    checkCount++;
    if (rdVal !== expHi) $display("[TB] FAIL snap_hi: got %h want %h", rdVal, expHi);
    else passCount++;
  endtask

  task automatic test_back_to_back;
    applyWrite(A_CMP0, 32'h5A5A_0000, 3'b100);
    applyRead(A_CMP0, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h5A5A_FFFF) $display("[TB] FAIL cmp_lane2: got %h want %h", rdVal, 32'h5A5A_FFFF);
    else passCount++;
    memory_address        = A_CMP0H;
    memory_write_value    = 32'h1234_5678;
    memory_write_sections = 3'b111;
    memory_read_enable    = 1'b1;
    @(negedge clk24);
    memory_write_sections = 3'b000;
    memory_read_enable    = 1'b0;
    memory_address        = 32'h0;
    checkCount++;
    if (read_value !== 32'hFFFF_FFFF || read_hit !== 1'b1) $display("[TB] FAIL rw_same_cycle: got %h hit %b want ffffffff hit 1", read_value, read_hit);
    else passCount++;
    applyRead(A_CMP0H, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h1234_5678) $display("[TB] FAIL rw_after: got %h want %h", rdVal, 32'h1234_5678);
    else passCount++;
    applyWrite(A_CMP1, 32'h0, 3'b111);
    applyWrite(A_CMP1H, 32'h0, 3'b111);
    applyWrite(A_PEND, 32'hFFFF_FFFF, 3'b111);
    applyRead(A_PEND, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h2) $display("[TB] FAIL pend_readonly: got %h want %h", rdVal, 32'h2);
    else passCount++;
  endtask

  task automatic test_async_reset;
    checkCount++;
    if (timer_irq !== 2'b10) $display("[TB] FAIL pre_reset_irq: got %b want 10", timer_irq);
    else passCount++;
    memory_address = A_MTIME;
    @(negedge clk24);
    #2 reset_n = 1'b0;
    #1;
    checkCount++;
    if (read_hit !== 1'b0 || read_value !== 32'h0) $display("[TB] FAIL async_rst_read: got %h hit %b want 0 hit 0", read_value, read_hit);
    else passCount++;
    checkCount++;
    if (timer_irq !== 2'b00 || timer_irq_any !== 1'b0) $display("[TB] FAIL async_rst_irq: got %b any %b want 00 any 0", timer_irq, timer_irq_any);
    else passCount++;
    @(negedge clk24);
    memory_address = 32'h0;
    @(negedge clk24);
    reset_n = 1'b1;
    repeat (5) @(negedge clk24);
    applyRead(A_MTIME, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'd5) $display("[TB] FAIL resume_count: got %0d want 5", rdVal);
    else passCount++;
    applyRead(A_CTRL, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'h0003_0001) $display("[TB] FAIL ctrl_reset: got %h want %h", rdVal, 32'h0003_0001);
    else passCount++;
    applyRead(A_CMP1H, rdVal, rdHit);
    checkCount++;
    if (rdVal !== 32'hFFFF_FFFF) $display("[TB] FAIL cmp_reset: got %h want %h", rdVal, 32'hFFFF_FFFF);
    else passCount++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_prescaler();
    test_irq();
    test_byte_write();
    test_wrap();
    test_snapshot();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
